// File: rtl/grad_seq_ctrl.sv
// Gradient playback sequencer: runs repeat_i+1 passes of length_i words from start_offset_i.
// Optional stall watchdog enabled by defining GRAD_SEQ_WATCHDOG_EN.
module grad_seq_ctrl #(
    parameter int unsigned LOAD_CYCLES = 2,
    parameter logic [19:0] WDOG_CYCLES = 20'hFFFFF
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        trig_i,
    input  logic        abort_i,
    input  logic [15:0] start_offset_i,
    input  logic [15:0] length_i,
    input  logic [7:0]  repeat_i,
    input  logic        word_strobe_i,
    input  logic        data_lost_i,
    output logic [15:0] offset_o,
    output logic        data_enb_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] word_cnt_o,
    output logic [7:0]  pass_cnt_o,
    output logic [3:0]  status_o,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);

    state_e      state;
    logic [15:0] len_q;
    logic [7:0]  rep_q;
    logic [15:0] load_cnt;
    logic [2:0]  flags;        // {abort, len_err, data_lost}
    logic        timeout_flag;
    logic        end_of_pass;

    assign end_of_pass = (word_cnt_o == len_q - 16'd1);
    assign status_o    = {timeout_flag, flags};
    assign state_dbg   = state;

`ifdef GRAD_SEQ_WATCHDOG_EN
    logic [19:0] wdog_cnt;
    logic        wdog_hit;
    assign wdog_hit = (wdog_cnt == WDOG_CYCLES - 20'd1);
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state      <= IDLE;
            len_q      <= '0;
            rep_q      <= '0;
            load_cnt   <= '0;
            offset_o   <= '0;
            data_enb_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            word_cnt_o <= '0;
            pass_cnt_o <= '0;
            flags      <= '0;
`ifdef GRAD_SEQ_WATCHDOG_EN
            wdog_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            // A clearing trigger below overrides this in the same cycle.
            if (data_lost_i) flags[0] <= 1'b1;

            case (state)
                IDLE: begin
                    if (trig_i) begin
`ifdef GRAD_SEQ_WATCHDOG_EN
                        timeout_flag <= 1'b0;
`endif
                        if (length_i != 16'd0) begin
                            offset_o   <= start_offset_i;
                            len_q      <= length_i;
                            rep_q      <= repeat_i;
                            word_cnt_o <= '0;
                            pass_cnt_o <= '0;
                            flags      <= '0;
                            load_cnt   <= '0;
                            busy_o     <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            flags  <= 3'b010;
                            done_o <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (abort_i) begin
                        flags[2]   <= 1'b1;
                        done_o     <= 1'b1;
                        data_enb_o <= 1'b0;
                        state      <= DONE;
                    end else if (load_cnt == LOAD_LAST) begin
                        data_enb_o <= 1'b1;
                        state      <= RUN;
`ifdef GRAD_SEQ_WATCHDOG_EN
                        wdog_cnt   <= '0;
`endif
                    end else begin
                        load_cnt <= load_cnt + 16'd1;
                    end
                end

                RUN: begin
                    if (abort_i) begin
                        flags[2]   <= 1'b1;
                        done_o     <= 1'b1;
                        data_enb_o <= 1'b0;
                        state      <= DONE;
                    end else if (word_strobe_i) begin
`ifdef GRAD_SEQ_WATCHDOG_EN
                        wdog_cnt <= '0;
`endif
                        if (end_of_pass) begin
                            // Saturate so repeat=255 ends with 255 rather than wrapping to 0.
                            if (pass_cnt_o != 8'hFF) pass_cnt_o <= pass_cnt_o + 8'd1;
                            if (pass_cnt_o == rep_q) begin
                                word_cnt_o <= word_cnt_o + 16'd1;
                                done_o     <= 1'b1;
                                data_enb_o <= 1'b0;
                                state      <= DONE;
                            end else begin
                                word_cnt_o <= '0;
                                load_cnt   <= '0;
                                data_enb_o <= 1'b0;
                                state      <= LOAD;
                            end
                        end else begin
                            word_cnt_o <= word_cnt_o + 16'd1;
                        end
                    end
`ifdef GRAD_SEQ_WATCHDOG_EN
                    else if (wdog_hit) begin
                        timeout_flag <= 1'b1;
                        done_o       <= 1'b1;
                        data_enb_o   <= 1'b0;
                        state        <= DONE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 20'd1;
                    end
`endif
                end

                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grad_seq_ctrl.sv
// Directed bench for grad_seq_ctrl (LOAD_CYCLES=2, WDOG_CYCLES=100); honours GRAD_SEQ_WATCHDOG_EN.
module tb_grad_seq_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig  = 1'b0;
    logic        abort = 1'b0;
    logic        strobe = 1'b0;
    logic        lost  = 1'b0;
    logic [15:0] start_offset = '0;
    logic [15:0] length = '0;
    logic [7:0]  rpt = '0;

    logic [15:0] offset;
    logic        enb;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;
    logic [7:0]  pass_cnt;
    logic [3:0]  status;
    logic [1:0]  state_dbg;

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;

    grad_seq_ctrl #(.LOAD_CYCLES(2), .WDOG_CYCLES(20'd100)) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .trig_i         (trig),
        .abort_i        (abort),
        .start_offset_i (start_offset),
        .length_i       (length),
        .repeat_i       (rpt),
        .word_strobe_i  (strobe),
        .data_lost_i    (lost),
        .offset_o       (offset),
        .data_enb_o     (enb),
        .busy_o         (busy),
        .done_o         (done),
        .word_cnt_o     (word_cnt),
        .pass_cnt_o     (pass_cnt),
        .status_o       (status),
        .state_dbg      (state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_seen++;

    initial begin
        #300000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_strobe();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
    endtask

    task automatic start(input logic [15:0] off, input logic [15:0] len, input logic [7:0] r);
        start_offset = off;
        length       = len;
        rpt          = r;
        trig         = 1'b1;
        step();
        trig         = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_offset"}, 32'(offset), 32'd0);
        chk({tag, "_enb"},    32'(enb),    32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_word"},   32'(word_cnt), 32'd0);
        chk({tag, "_pass"},   32'(pass_cnt), 32'd0);
        chk({tag, "_status"}, 32'(status), 32'd0);
        chk({tag, "_state"},  32'(state_dbg), 32'(S_IDLE));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk_all_zero("rst");
        rst_n = 1'b1;
        step();

        // Single pass: offset 10, length 3
        start(16'd10, 16'd3, 8'd0);
        chk("t1_offset", 32'(offset), 32'd10);
        chk("t1_enb_load1", 32'(enb), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_enb_load2", 32'(enb), 32'd0);
        step();
        chk("t1_enb_run", 32'(enb), 32'd1);
        pulse_strobe();
        chk("t1_word1", 32'(word_cnt), 32'd1);
        pulse_strobe();
        chk("t1_word2", 32'(word_cnt), 32'd2);
        chk("t1_no_done_early", 32'(done), 32'd0);
        pulse_strobe();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_enb_off", 32'(enb), 32'd0);
        chk("t1_pass", 32'(pass_cnt), 32'd1);
        chk("t1_status", 32'(status), 32'd0);
        step();
        chk("t1_done_clr", 32'(done), 32'd0);
        chk("t1_idle", 32'(state_dbg), 32'(S_IDLE));
        step();
        chk("t1_pass_hold", 32'(pass_cnt), 32'd1);
        chk("t1_offset_hold", 32'(offset), 32'd10);

        // Three passes of length 2
        done_seen = 0;
        start(16'd0, 16'd2, 8'd2);
        for (int p = 0; p < 3; p++) begin
            chk("t2_gap_a", 32'(enb), 32'd0);
            chk("t2_word_start", 32'(word_cnt), 32'd0);
            chk("t2_pass_start", 32'(pass_cnt), 32'(p));
            step();
            chk("t2_gap_b", 32'(enb), 32'd0);
            step();
            chk("t2_run", 32'(enb), 32'd1);
            pulse_strobe();
            chk("t2_word_mid", 32'(word_cnt), 32'd1);
            pulse_strobe();
        end
        chk("t2_pass_end", 32'(pass_cnt), 32'd3);
        chk("t2_done", 32'(done), 32'd1);
        step();
        step();
        chk("t2_done_count", 32'(done_seen), 32'd1);

        // repeat=255 gives 256 passes and pass count saturates at 255
        done_seen = 0;
        start(16'd1, 16'd1, 8'd255);
        for (int p = 0; p < 256; p++) begin
            step();
            step();
            pulse_strobe();
        end
        chk("t6_pass_sat", 32'(pass_cnt), 32'd255);
        chk("t6_done", 32'(done), 32'd1);
        step();
        step();
        chk("t6_done_count", 32'(done_seen), 32'd1);

        // Abort on the 2nd strobe; trigger during RUN is ignored
        start(16'd7, 16'd5, 8'd0);
        step();
        step();
        chk("t3_run", 32'(enb), 32'd1);
        start_offset = 16'd99;
        length       = 16'd0;
        trig         = 1'b1;
        step();
        trig         = 1'b0;
        chk("t3_trig_state", 32'(state_dbg), 32'(S_RUN));
        chk("t3_trig_offset", 32'(offset), 32'd7);
        chk("t3_trig_status", 32'(status), 32'd0);
        chk("t3_trig_done", 32'(done), 32'd0);
        pulse_strobe();
        chk("t3_word1", 32'(word_cnt), 32'd1);
        strobe = 1'b1;
        abort  = 1'b1;
        step();
        strobe = 1'b0;
        abort  = 1'b0;
        chk("t3_abort_done", 32'(done), 32'd1);
        chk("t3_abort_word", 32'(word_cnt), 32'd1);
        chk("t3_abort_status", 32'(status), 32'b0100);
        chk("t3_abort_enb", 32'(enb), 32'd0);
        step();
        chk("t3_idle", 32'(state_dbg), 32'(S_IDLE));
        chk("t3_status_hold", 32'(status), 32'b0100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_idle_abort_status", 32'(status), 32'b0100);
        chk("t3_idle_abort_busy", 32'(busy), 32'd0);

        // Zero length trigger
        done_seen = 0;
        length = 16'd0;
        trig   = 1'b1;
        step();
        trig   = 1'b0;
        chk("t4_status", 32'(status), 32'b0010);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        step();
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_state", 32'(state_dbg), 32'(S_IDLE));
        chk("t4_done_count", 32'(done_seen), 32'd1);

        // data_lost in the clearing trigger cycle is dropped, later ones stick
        start_offset = 16'd3;
        length       = 16'd4;
        rpt          = 8'd0;
        trig         = 1'b1;
        lost         = 1'b1;
        step();
        trig         = 1'b0;
        lost         = 1'b0;
        chk("t5_status_cleared", 32'(status), 32'd0);
        step();
        step();
        chk("t5_run", 32'(state_dbg), 32'(S_RUN));
        lost = 1'b1;
        step();
        lost = 1'b0;
        chk("t5_lost", 32'(status), 32'b0001);

        // Stall in RUN with no strobes
`ifdef GRAD_SEQ_WATCHDOG_EN
        repeat (98) step();
        chk("t5_wdog_before", 32'(state_dbg), 32'(S_RUN));
        step();
        chk("t5_wdog_done", 32'(done), 32'd1);
        chk("t5_wdog_state", 32'(state_dbg), 32'(S_DONE));
        chk("t5_wdog_status", 32'(status), 32'b1001);
        step();
`else
        repeat (120) step();
        chk("t5_stay_run", 32'(state_dbg), 32'(S_RUN));
        chk("t5_stay_enb", 32'(enb), 32'd1);
        chk("t5_no_timeout", 32'(status), 32'b0001);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_exit_done", 32'(done), 32'd1);
        step();
`endif

        // Asynchronous reset mid-RUN, then retrigger
        done_seen = 0;
        start(16'd20, 16'd8, 8'd0);
        step();
        step();
        pulse_strobe();
        lost = 1'b1;
        step();
        lost = 1'b0;
        chk("t7_word_pre", 32'(word_cnt), 32'd1);
        chk("t7_status_pre", 32'(status), 32'b0001);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t7_async");
        #2;
        rst_n = 1'b1;
        step();
        step();
        chk("t7_no_done", 32'(done_seen), 32'd0);
        chk("t7_idle", 32'(state_dbg), 32'(S_IDLE));
        start(16'd5, 16'd2, 8'd0);
        lost = 1'b1;
        step();
        lost = 1'b0;
        chk("t7_lost", 32'(status), 32'b0001);
        chk("t7_offset", 32'(offset), 32'd5);
        chk("t7_state", 32'(state_dbg), 32'(S_LOAD));

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
